// File: rtl/fread_arbiter_pkg.sv
// Shared types for the fread arbiter: FSM encoding and request field widths.
package fread_arbiter_pkg;
  localparam int FID_W = 32;
  localparam int OFF_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/fread_arbiter_rr.sv
// Round-robin picker: searches from (last owner + 1) mod N_REQ and returns the
// first active requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int OWN_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [OWN_W-1:0] i_last,
  output logic [N_REQ-1:0] o_gnt,
  output logic [OWN_W-1:0] o_idx,
  output logic             o_any
);
  int   w_pos;
  logic w_found;

  assign o_any = |i_req;

  always_comb begin
    o_gnt   = '0;
    o_idx   = i_last;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos = (int'(i_last) + k) % N_REQ;
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos[OWN_W-1:0];
      end
    end
  end
endmodule

// File: rtl/fread_arbiter.sv
// N-way fread request arbiter feeding one downstream port; bytes are forwarded
// combinationally to the owner. Define FREAD_ARB_TIMEOUT_EN for the idle timeout.
module fread_arbiter
  import fread_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             i_cli_req_valid,
  output logic [N_REQ-1:0]             o_cli_req_ready,
  input  logic [N_REQ-1:0][FID_W-1:0]  i_cli_req_fid,
  input  logic [N_REQ-1:0][OFF_W-1:0]  i_cli_req_offset,
  input  logic [N_REQ-1:0][LEN_W-1:0]  i_cli_req_len,
  output logic [7:0]                   o_cli_resp_data,
  output logic [N_REQ-1:0]             o_cli_resp_valid,
  output logic [N_REQ-1:0]             o_cli_done,
  output logic [N_REQ-1:0]             o_cli_err,
  output logic                         o_req_valid,
  input  logic                         i_req_ready,
  output logic [FID_W-1:0]             o_req_fid,
  output logic [OFF_W-1:0]             o_req_offset,
  output logic [LEN_W-1:0]             o_req_len,
  input  logic [7:0]                   i_resp_data,
  input  logic                         i_resp_valid
);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fread_arbiter: unsupported N_REQ/TIMEOUT");
  end

  state_e           r_state, w_next;
  logic [OWN_W-1:0] r_owner, w_gnt_idx;
  logic [N_REQ-1:0] w_gnt;
  logic             w_any, w_grant, w_byte, w_tmo;
  logic [FID_W-1:0] r_fid;
  logic [OFF_W-1:0] r_off;
  logic [LEN_W-1:0] r_len, r_remain;

  rr_arbiter #(.N_REQ(N_REQ), .OWN_W(OWN_W)) u_rr (
    .i_req  (i_cli_req_valid),
    .i_last (r_owner),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  // Grant is masked during reset so no ready pulse escapes while rst is high.
  assign w_grant = (r_state == ST_IDLE) && w_any && !rst;
  assign w_byte  = (r_state == ST_STREAM) && i_resp_valid;

`ifdef FREAD_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             w_wait, w_evt;

  assign w_wait = (r_state == ST_ISSUE) || (r_state == ST_STREAM);
  assign w_evt  = i_resp_valid || i_req_ready;
  // r_tmo holds the number of idle cycles already seen; this cycle is the next.
  assign w_tmo  = w_wait && !w_evt && (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_tmo <= '0;
    else if (!w_wait || w_evt || w_tmo) r_tmo <= '0;
    else                              r_tmo <= r_tmo + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next           = r_state;
    o_cli_req_ready  = '0;
    o_req_valid      = 1'b0;
    o_cli_resp_valid = '0;
    o_cli_done       = '0;
    o_cli_err        = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          o_cli_req_ready = w_gnt;
          w_next = (i_cli_req_len[w_gnt_idx] == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_req_valid = 1'b1;
        if (w_tmo) begin
          o_cli_err[r_owner] = 1'b1;
          w_next = ST_IDLE;
        end else if (i_req_ready) begin
          w_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (i_resp_valid) begin
          o_cli_resp_valid[r_owner] = 1'b1;
          if (r_remain == LEN_W'(1)) w_next = ST_DONE;
        end else if (w_tmo) begin
          o_cli_err[r_owner] = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        o_cli_done[r_owner] = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_W'(N_REQ - 1);
    end else begin
      r_state <= w_next;
      if (w_grant) r_owner <= w_gnt_idx;
    end
  end

  // Request fields are only meaningful behind req_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_fid    <= i_cli_req_fid[w_gnt_idx];
      r_off    <= i_cli_req_offset[w_gnt_idx];
      r_len    <= i_cli_req_len[w_gnt_idx];
      r_remain <= i_cli_req_len[w_gnt_idx];
    end else if (w_byte && r_remain != '0) begin
      r_remain <= r_remain - 1'b1;
    end
  end

  assign o_req_fid       = r_fid;
  assign o_req_offset    = r_off;
  assign o_req_len       = r_len;
  assign o_cli_resp_data = i_resp_data;
endmodule
